// File: rtl/multi_port_csr_scheduler_pkg.sv
// Shared types and constants for the CSR path scheduler and its poll timer.
package multi_port_csr_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOST,
        POLL
    } state_e;

    typedef enum logic {
        GNT_HOST,
        GNT_POLL
    } grant_e;

    localparam int unsigned OOR_READ_VALUE = 0;

endpackage

// File: rtl/csr_poll_timer.sv
// Free-running poll period counter that raises poll_pending once per period
// and flags an overrun when a period expires before the previous pass ends.
module csr_poll_timer #(
    parameter int unsigned POLL_PERIOD = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_poll_en,
    input  logic i_pass_end,
    output logic o_poll_pending,
    output logic o_poll_overrun
);
    localparam int unsigned CNT_W = $clog2(POLL_PERIOD);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POLL_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (!i_poll_en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            expire = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // A pass ending in the same cycle as an expiry frees the slot for the new request.
        pending_d = (pending_q & ~i_pass_end) | expire;
        overrun_d = overrun_q | (expire & pending_q & ~i_pass_end);
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_poll_pending = pending_q;
    assign o_poll_overrun = overrun_q;

endmodule

// File: rtl/multi_port_csr_scheduler.sv
// Shares one downstream CSR Avalon-MM path between the host master and a
// statistics poller that reads POLL_ADDR from each Ethernet port in turn.
module multi_port_csr_scheduler
    import multi_port_csr_scheduler_pkg::*;
#(
    parameter int unsigned              NUM_ETH     = 1,
    parameter int unsigned              AVMM_DATA_W = 32,
    parameter int unsigned              AVMM_ADDR_W = 16,
    parameter logic [AVMM_ADDR_W-1:0]   POLL_ADDR   = 16'h0010,
    parameter int unsigned              POLL_PERIOD = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [AVMM_ADDR_W-1:0]         i_host_addr,
    input  logic                           i_host_read,
    input  logic                           i_host_write,
    input  logic [AVMM_DATA_W-1:0]         i_host_writedata,
    input  logic [3:0]                     i_host_port_sel,
    output logic [AVMM_DATA_W-1:0]         o_host_readdata,
    output logic                           o_host_waitrequest,
    output logic [AVMM_ADDR_W-1:0]         o_avmm_addr,
    output logic                           o_avmm_read,
    output logic                           o_avmm_write,
    output logic [AVMM_DATA_W-1:0]         o_avmm_writedata,
    input  logic [AVMM_DATA_W-1:0]         i_avmm_readdata,
    input  logic                           i_avmm_waitrequest,
    output logic [3:0]                     o_csr_port_sel,
    input  logic                           i_poll_en,
    output logic [NUM_ETH*AVMM_DATA_W-1:0] o_poll_data,
    output logic                           o_poll_done,
    output logic                           o_poll_overrun
);
    localparam int unsigned      IDX_W     = (NUM_ETH > 1) ? $clog2(NUM_ETH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ETH - 1);
    localparam logic [4:0]       NUM_ETH_L = 5'(NUM_ETH);

    state_e                   state_q;
    grant_e                   last_grant_q;
    logic [IDX_W-1:0]         poll_idx_q;
    logic                     host_oor_q;
    logic                     poll_done_q;
    logic [AVMM_ADDR_W-1:0]   avmm_addr_q;
    logic [AVMM_DATA_W-1:0]   avmm_writedata_q;
    logic [3:0]               port_sel_q;
    logic                     avmm_read_q;
    logic                     avmm_write_q;
    logic [AVMM_DATA_W-1:0]   poll_data_q [NUM_ETH];

    logic host_req;
    logic host_in_range;
    logic host_done;
    logic poll_xfer_done;
    logic pass_end;
    logic poll_pending;
    logic grant_host;

    assign host_req       = i_host_read | i_host_write;
    assign host_in_range  = {1'b0, i_host_port_sel} < NUM_ETH_L;
    assign host_done      = (state_q == HOST) & (host_oor_q | ~i_avmm_waitrequest);
    assign poll_xfer_done = (state_q == POLL) & ~i_avmm_waitrequest;
    assign pass_end       = poll_xfer_done & (poll_idx_q == LAST_IDX);
    // Round-robin: on contention the host wins only if the poller had the last grant.
    assign grant_host     = host_req & (~poll_pending | (last_grant_q == GNT_POLL));

    csr_poll_timer #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_poll_timer (
        .clk           (clk),
        .reset         (reset),
        .i_poll_en     (i_poll_en),
        .i_pass_end    (pass_end),
        .o_poll_pending(poll_pending),
        .o_poll_overrun(o_poll_overrun)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            last_grant_q     <= GNT_POLL;
            poll_idx_q       <= '0;
            host_oor_q       <= 1'b0;
            poll_done_q      <= 1'b0;
            avmm_addr_q      <= '0;
            avmm_writedata_q <= '0;
            port_sel_q       <= '0;
            avmm_read_q      <= 1'b0;
            avmm_write_q     <= 1'b0;
            // NOTE: the poll results are architecturally visible from reset, so this small array is reset too.
            for (int i = 0; i < int'(NUM_ETH); i++) begin
                poll_data_q[i] <= '0;
            end
        end else begin
            poll_done_q <= pass_end;
            unique case (state_q)
                IDLE: begin
                    if (grant_host) begin
                        state_q          <= HOST;
                        last_grant_q     <= GNT_HOST;
                        host_oor_q       <= ~host_in_range;
                        avmm_addr_q      <= i_host_addr;
                        avmm_writedata_q <= i_host_writedata;
                        port_sel_q       <= i_host_port_sel;
                        avmm_read_q      <= host_in_range & i_host_read;
                        avmm_write_q     <= host_in_range & i_host_write & ~i_host_read;
                    end else if (poll_pending) begin
                        state_q          <= POLL;
                        last_grant_q     <= GNT_POLL;
                        host_oor_q       <= 1'b0;
                        avmm_addr_q      <= POLL_ADDR;
                        avmm_writedata_q <= '0;
                        port_sel_q       <= 4'(poll_idx_q);
                        avmm_read_q      <= 1'b1;
                        avmm_write_q     <= 1'b0;
                    end
                end
                HOST: begin
                    if (host_done) begin
                        state_q      <= IDLE;
                        avmm_read_q  <= 1'b0;
                        avmm_write_q <= 1'b0;
                    end
                end
                POLL: begin
                    if (poll_xfer_done) begin
                        state_q                 <= IDLE;
                        avmm_read_q             <= 1'b0;
                        poll_data_q[poll_idx_q] <= i_avmm_readdata;
                        poll_idx_q              <= (poll_idx_q == LAST_IDX) ? '0 : poll_idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_ETH; g++) begin : g_poll_out
        assign o_poll_data[g*AVMM_DATA_W +: AVMM_DATA_W] = poll_data_q[g];
    end

    // Out-of-range reads never raise a strobe, so they fall through to the constant.
    assign o_host_readdata    = (host_done & avmm_read_q) ? i_avmm_readdata
                                                          : AVMM_DATA_W'(OOR_READ_VALUE);
    assign o_host_waitrequest = ~host_done;
    assign o_avmm_addr        = avmm_addr_q;
    assign o_avmm_writedata   = avmm_writedata_q;
    assign o_avmm_read        = avmm_read_q;
    assign o_avmm_write       = avmm_write_q;
    assign o_csr_port_sel     = port_sel_q;
    assign o_poll_done        = poll_done_q;

endmodule

// File: tb/tb_multi_port_csr_scheduler.sv
// Self-checking bench: transaction-level scheduler model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_multi_port_csr_scheduler;
    localparam int          N        = 4;
    localparam int          P        = 16;
    localparam logic [15:0] POLL_A   = 16'h0010;

    logic         clk;
    logic         reset;
    logic [15:0]  i_host_addr;
    logic         i_host_read;
    logic         i_host_write;
    logic [31:0]  i_host_writedata;
    logic [3:0]   i_host_port_sel;
    logic [31:0]  o_host_readdata;
    logic         o_host_waitrequest;
    logic [15:0]  o_avmm_addr;
    logic         o_avmm_read;
    logic         o_avmm_write;
    logic [31:0]  o_avmm_writedata;
    logic [31:0]  i_avmm_readdata;
    logic         i_avmm_waitrequest;
    logic [3:0]   o_csr_port_sel;
    logic         i_poll_en;
    logic [127:0] o_poll_data;
    logic         o_poll_done;
    logic         o_poll_overrun;

    multi_port_csr_scheduler #(
        .NUM_ETH    (N),
        .AVMM_DATA_W(32),
        .AVMM_ADDR_W(16),
        .POLL_ADDR  (POLL_A),
        .POLL_PERIOD(P)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_host_addr       (i_host_addr),
        .i_host_read       (i_host_read),
        .i_host_write      (i_host_write),
        .i_host_writedata  (i_host_writedata),
        .i_host_port_sel   (i_host_port_sel),
        .o_host_readdata   (o_host_readdata),
        .o_host_waitrequest(o_host_waitrequest),
        .o_avmm_addr       (o_avmm_addr),
        .o_avmm_read       (o_avmm_read),
        .o_avmm_write      (o_avmm_write),
        .o_avmm_writedata  (o_avmm_writedata),
        .i_avmm_readdata   (i_avmm_readdata),
        .i_avmm_waitrequest(i_avmm_waitrequest),
        .o_csr_port_sel    (o_csr_port_sel),
        .i_poll_en         (i_poll_en),
        .o_poll_data       (o_poll_data),
        .o_poll_done       (o_poll_done),
        .o_poll_overrun    (o_poll_overrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream slave: wait_cfg wait states per access; accesses to stall_port never finish.
    int          wait_cfg      = 0;
    int          stall_port    = -1;
    logic [31:0] host_rd_value = 32'h0;
    int          ws            = 0;

    initial begin
        i_avmm_waitrequest = 1'b0;
        i_avmm_readdata    = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (o_avmm_read || o_avmm_write) begin
                if (int'(o_csr_port_sel) == stall_port) begin
                    i_avmm_waitrequest = 1'b1;
                end else if (ws < wait_cfg) begin
                    i_avmm_waitrequest = 1'b1;
                    ws++;
                end else begin
                    i_avmm_waitrequest = 1'b0;
                    ws = 0;
                end
                i_avmm_readdata = (o_avmm_addr == POLL_A) ? 32'h100 + 32'(o_csr_port_sel)
                                                          : host_rd_value;
            end else begin
                i_avmm_waitrequest = 1'b0;
                i_avmm_readdata    = 32'hDEAD_BEEF;
                ws                 = 0;
            end
        end
    end

    // Transaction-level model: one outstanding access (owner, target), a poll
    // pass cursor, a period counter and the round-robin memory.
    bit          m_busy, m_is_poll, m_rd, m_wr, m_oor;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_port;
    int          m_cnt, m_idx;
    bit          m_pending, m_overrun, m_done, m_last_host;
    logic [31:0] m_data [N];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_is_poll = 0; m_rd = 0; m_wr = 0; m_oor = 0;
            m_addr = '0; m_wdata = '0; m_port = '0;
            m_cnt = 0; m_idx = 0; m_pending = 0; m_overrun = 0; m_done = 0; m_last_host = 0;
            for (int i = 0; i < N; i++) m_data[i] = '0;
        end else begin
            bit complete, pass_end, expiry;
            complete = m_busy && (m_oor || !i_avmm_waitrequest);
            pass_end = complete && m_is_poll && (m_idx == N - 1);
            expiry   = i_poll_en && (m_cnt == P - 1);
            m_done   = pass_end;
            if (complete) begin
                if (m_is_poll) begin
                    m_data[m_idx] = i_avmm_readdata;
                    m_idx = (m_idx + 1) % N;
                end
                m_busy = 0; m_rd = 0; m_wr = 0;
            end else if (!m_busy) begin
                if ((i_host_read || i_host_write) && (!m_pending || !m_last_host)) begin
                    m_busy = 1; m_is_poll = 0; m_last_host = 1;
                    m_addr = i_host_addr; m_wdata = i_host_writedata; m_port = i_host_port_sel;
                    m_oor = (int'(i_host_port_sel) >= N);
                    m_rd = i_host_read; m_wr = i_host_write && !i_host_read;
                end else if (m_pending) begin
                    m_busy = 1; m_is_poll = 1; m_last_host = 0;
                    m_addr = POLL_A; m_wdata = '0; m_port = 4'(m_idx);
                    m_oor = 0; m_rd = 1; m_wr = 0;
                end
            end
            m_cnt = !i_poll_en ? 0 : ((m_cnt == P - 1) ? 0 : m_cnt + 1);
            if (expiry && m_pending && !pass_end) m_overrun = 1;
            m_pending = (m_pending && !pass_end) || expiry;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            logic         host_fin;
            logic [127:0] exp_pd;
            @(negedge clk);
            #1;
            host_fin = m_busy && !m_is_poll && (m_oor || !i_avmm_waitrequest);
            for (int i = 0; i < N; i++) exp_pd[i*32 +: 32] = m_data[i];
            check("avmm_read",    o_avmm_read,  m_busy && m_rd && !m_oor);
            check("avmm_write",   o_avmm_write, m_busy && m_wr && !m_oor);
            check("avmm_addr",    o_avmm_addr,  m_addr);
            check("avmm_wdata",   o_avmm_writedata, m_wdata);
            check("csr_port_sel", o_csr_port_sel, m_port);
            check("host_wait",    o_host_waitrequest, !host_fin);
            check("host_rdata",   o_host_readdata,
                  (host_fin && m_rd && !m_oor) ? i_avmm_readdata : 32'h0);
            check("poll_data",    o_poll_data, exp_pd);
            check("poll_done",    o_poll_done, m_done);
            check("poll_overrun", o_poll_overrun, m_overrun);
        end
    end

    // Completed downstream accesses, 1 = poll, 0 = host.
    bit rec_en = 0;
    bit owners[$];
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rec_en && (o_avmm_read || o_avmm_write) && !i_avmm_waitrequest)
                owners.push_back(o_avmm_addr == POLL_A);
        end
    end

    task automatic host_access(input bit wr, input logic [3:0] port, input logic [15:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output int cycles, output int strobes,
                               output logic [3:0] sel1, output logic wr1);
        bit fin = 0;
        @(negedge clk);
        i_host_read = !wr; i_host_write = wr;
        i_host_addr = addr; i_host_writedata = wdata; i_host_port_sel = port;
        cycles = 1; strobes = 0; rdata = '0; sel1 = '0; wr1 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #2;
            cycles++;
            if (o_avmm_read || o_avmm_write) strobes++;
            if (cycles == 2) begin sel1 = o_csr_port_sel; wr1 = o_avmm_write; end
            if (!o_host_waitrequest) begin rdata = o_host_readdata; fin = 1; break; end
        end
        check("host_completes", fin, 1'b1);
        @(negedge clk);
        i_host_read = 0; i_host_write = 0;
    endtask

    task automatic wait_done(input string name, output int at);
        bit got = 0;
        at = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #2;
            if (o_poll_done) begin at = k; got = 1; break; end
        end
        check(name, got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        int          cyc, stb, done_at, extra_done, hosts, polls;
        logic [3:0]  sel1;
        logic        wr1;
        logic [14:0] order;
        bit          found;

        reset = 1; i_poll_en = 0;
        i_host_read = 0; i_host_write = 0; i_host_addr = '0; i_host_writedata = '0; i_host_port_sel = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_wait",    o_host_waitrequest, 1'b1);
        check("rst_strobes", {o_avmm_read, o_avmm_write}, 2'b00);
        check("rst_addr",    {o_avmm_addr, o_avmm_writedata, o_csr_port_sel}, '0);
        check("rst_poll",    {o_poll_data, o_poll_done, o_poll_overrun}, '0);
        check("rst_rdata",   o_host_readdata, 32'h0);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);

        // Host write, zero wait states.
        host_access(1, 4'd2, 16'h0004, 32'hA5A5_0001, rdata, cyc, stb, sel1, wr1);
        check("wr_cycles", cyc, 2);
        check("wr_strobes", stb, 1);
        check("wr_port_n1", sel1, 4'd2);
        check("wr_strobe_n1", wr1, 1'b1);

        // Host read, three wait states.
        wait_cfg = 3; host_rd_value = 32'h1234_5678;
        host_access(0, 4'd1, 16'h0008, 32'h0, rdata, cyc, stb, sel1, wr1);
        check("rd_cycles", cyc, 5);
        check("rd_strobes", stb, 4);
        check("rd_data", rdata, 32'h1234_5678);
        wait_cfg = 0;

        // Host read to a port that does not exist.
        host_access(0, 4'd7, 16'h0008, 32'h0, rdata, cyc, stb, sel1, wr1);
        check("oor_cycles", cyc, 2);
        check("oor_strobes", stb, 0);
        check("oor_data", rdata, 32'h0);
        host_access(1, 4'd9, 16'h000C, 32'hFFFF_0000, rdata, cyc, stb, sel1, wr1);
        check("oor_wr_strobes", stb, 0);

        // One full poll pass on its own.
        @(negedge clk);
        i_poll_en = 1;
        wait_done("pass1_done", done_at);
        i_poll_en = 0;
        check("pass1_done_cycle", done_at, 24);
        check("pass1_data", o_poll_data, {32'h103, 32'h102, 32'h101, 32'h100});
        extra_done = 0;
        repeat (20) begin @(negedge clk); #2; if (o_poll_done) extra_done++; end
        check("pass1_single_pulse", extra_done, 0);

        // Back-to-back host reads contending with a pass.
        host_rd_value = 32'hCAFE_0003;
        owners.delete();
        rec_en = 1;
        @(negedge clk);
        i_poll_en = 1; i_host_read = 1; i_host_addr = 16'h0020; i_host_port_sel = 4'd3;
        hosts = 0;
        for (int k = 0; k < 200 && hosts < 11; k++) begin
            @(negedge clk);
            #2;
            if (!o_host_waitrequest) hosts++;
        end
        check("burst_hosts", hosts, 11);
        @(negedge clk);
        i_host_read = 0;
        wait_done("pass2_done", done_at);
        i_poll_en = 0;
        rec_en = 0;
        check("burst_total", owners.size(), 15);
        order = '0; polls = 0;
        for (int i = 0; i < owners.size() && i < 15; i++) begin
            order[i] = owners[i];
            polls += int'(owners[i]);
        end
        check("burst_polls", polls, 4);
        check("burst_order", order, 15'h5500);
        repeat (4) @(negedge clk);

        // Port 1 never answers: the next expiry finds the pass still pending.
        stall_port = 1;
        @(negedge clk);
        i_poll_en = 1;
        repeat (40) @(negedge clk);
        #2;
        check("stall_overrun", o_poll_overrun, 1'b1);
        check("stall_read", o_avmm_read, 1'b1);
        check("stall_port", o_csr_port_sel, 4'd1);
        check("stall_port0_data", o_poll_data[31:0], 32'h100);
        #1;
        reset = 1;
        #1;
        check("arst_strobes", {o_avmm_read, o_avmm_write}, 2'b00);
        check("arst_wait", o_host_waitrequest, 1'b1);
        check("arst_state", {o_poll_data, o_poll_overrun, o_poll_done, o_csr_port_sel, o_avmm_addr}, '0);
        @(negedge clk);
        stall_port = -1;
        @(negedge clk);
        reset = 0;

        // After reset the pass restarts from port 0.
        found = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #2;
            if (o_avmm_read) begin found = 1; break; end
        end
        check("restart_found", found, 1'b1);
        check("restart_port0", o_csr_port_sel, 4'd0);
        wait_done("pass3_done", done_at);
        i_poll_en = 0;
        check("pass3_data", o_poll_data, {32'h103, 32'h102, 32'h101, 32'h100});
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
